// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg
//   Definitions shared by the memory access controller: the FSM state
//   encoding, the default main store geometry and the saturating counter
//   helper.
package mem_access_ctrl_pkg;

    localparam int ADDR_W_DEFAULT = 5;
    localparam int DATA_W_DEFAULT = 8;
    localparam int COUNT_W        = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Add one and stick at all-ones.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == {COUNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Single-access memory controller between a CPU request/response port and
//   a main store with a combinational read. Each access goes
//   IDLE -> ACCESS -> RESP -> IDLE, so one access occupies at least three
//   cycles; requests seen outside IDLE are dropped, not queued.
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     req_valid/req_ready request handshake; req_we, req_addr, req_wdata
//     rsp_valid/rsp_ready response handshake; rsp_rdata (read data or
//                         write-data echo)
//     busy                1 whenever the FSM is not in IDLE
//     ms_read, ms_write   one-cycle main store strobes (ACCESS only)
//     ms_address          always the MAR
//     ms_data_i           always the MBR (write data to the store)
//     ms_data_o           store read data for ms_address
//     access_count        completed accesses, saturating at 255
//
//   Handshake rule: a transfer happens on a rising edge where valid and
//   ready are both 1. valid never depends on ready, and once rsp_valid is
//   raised it and rsp_rdata hold until the transfer edge.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              ms_read,
    output logic              ms_write,
    output logic [ADDR_W-1:0] ms_address,
    output logic [DATA_W-1:0] ms_data_i,
    input  logic [DATA_W-1:0] ms_data_o,
    output logic [7:0]        access_count
);

    state_e            state;
    state_e            state_next;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mbr;
    logic              we;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and outputs. The store strobes are decoded from the state
    // register, so an asynchronous reset during ACCESS removes ms_write
    // before the edge that would commit the write.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        ms_read    = 1'b0;
        ms_write   = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                ms_write   = we;
                ms_read    = !we;
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers and completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar          <= '0;
            mbr          <= '0;
            we           <= 1'b0;
            access_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mar <= req_addr;
                        mbr <= req_wdata;
                        we  <= req_we;
                    end
                end
                ACCESS: begin
                    // A write keeps its data in the MBR so it is echoed back.
                    if (!we) begin
                        mbr <= ms_data_o;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        access_count <= sat_inc(access_count);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ms_address = mar;
    assign ms_data_i  = mbr;
    assign rsp_rdata  = mbr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Directed bench for mem_access_ctrl with a behavioural main store
//   (combinational read, write on the rising edge while ms_write is high).
module tb_mem_access_ctrl;

    localparam int AW = 5;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          busy;
    logic          ms_read;
    logic          ms_write;
    logic [AW-1:0] ms_address;
    logic [DW-1:0] ms_data_i;
    logic [DW-1:0] ms_data_o;
    logic [7:0]    access_count;

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .busy         (busy),
        .ms_read      (ms_read),
        .ms_write     (ms_write),
        .ms_address   (ms_address),
        .ms_data_i    (ms_data_i),
        .ms_data_o    (ms_data_o),
        .access_count (access_count)
    );

    // ---------------- main store ----------------
    logic [DW-1:0] store [0:(1<<AW)-1];
    assign ms_data_o = store[ms_address];
    always @(posedge clk) begin
        if (ms_write) store[ms_address] <= ms_data_i;
    end

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] model_mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_q[$];
    int            exp_count;
    int            n_checks;
    int            n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver ----------------
    // Starts in IDLE just after an edge; returns just after the response
    // transfer edge, back in IDLE. hold = cycles of rsp_ready=0 in RESP;
    // poke = present an extra request during the hold.
    task automatic do_access(input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input int hold,
                             input logic poke);
        logic [DW-1:0] exp_data;
        exp_q.push_back(we ? wdata : model_mem[addr]);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
        // ACCESS
        check("acc_ms_write", ms_write, we);
        check("acc_ms_read", ms_read, !we);
        check("acc_ms_address", ms_address, addr);
        check("acc_ms_data_i", ms_data_i, wdata);
        check("acc_busy", busy, 1);
        check("acc_rsp_valid", rsp_valid, 0);
        check("acc_req_ready", req_ready, 0);
        if (we) model_mem[addr] = wdata;
        tick();
        // RESP
        exp_data = exp_q.pop_front();
        check("resp_rsp_valid", rsp_valid, 1);
        check("resp_rsp_rdata", rsp_rdata, exp_data);
        check("resp_strobes", {ms_read, ms_write}, 0);
        for (int i = 0; i < hold; i++) begin
            if (poke && i == 0) begin
                req_valid = 1'b1;
                req_we    = 1'b1;
                req_addr  = addr ^ 5'h01;
                req_wdata = ~wdata;
            end else begin
                req_valid = 1'b0;
            end
            check("hold_req_ready", req_ready, 0);
            tick();
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_rdata", rsp_rdata, exp_data);
            check("hold_strobes", {ms_read, ms_write}, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        if (exp_count < 255) exp_count++;
        check("done_rsp_valid", rsp_valid, 0);
        check("done_busy", busy, 0);
        check("done_count", access_count, exp_count);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_strobes"}, {ms_read, ms_write}, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check({tag, "_ms_address"}, ms_address, 0);
        check({tag, "_count"}, access_count, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_count = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            store[i]     = '0;
            model_mem[i] = '0;
        end
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        #2;
        check_reset_outputs("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_reset_outputs("post_reset");

        // Write then read back, plus an unwritten location.
        do_access(1'b1, 5'd5, 8'hA7, 0, 1'b0);
        check("first_write_count", access_count, 1);
        do_access(1'b0, 5'd5, 8'h3C, 0, 1'b0);
        do_access(1'b0, 5'd6, 8'h00, 0, 1'b0);

        // Stalled response with an ignored request during the stall.
        do_access(1'b0, 5'd5, 8'h11, 4, 1'b1);
        tick();
        check("no_queued_req_busy", busy, 0);
        check("no_queued_store", store[5'd4], 8'h00);

        // Boundary addresses.
        do_access(1'b1, 5'h1F, 8'hFF, 0, 1'b0);
        do_access(1'b1, 5'h00, 8'h01, 0, 1'b0);
        do_access(1'b0, 5'h1F, 8'h00, 0, 1'b0);
        do_access(1'b0, 5'h00, 8'h00, 1, 1'b0);

        // Reset during ACCESS of a write aborts it.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_count = 0;
        tick();
        check("rst2_count", access_count, 0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 5'd3;
        req_wdata = 8'h55;
        tick();
        req_valid = 1'b0;
        check("abort_in_access", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        tick();
        check("abort_rsp_valid", rsp_valid, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_store", store[5'd3], 8'h00);
        check("abort_count", access_count, 0);
        do_access(1'b0, 5'd3, 8'h9E, 0, 1'b0);

        // Saturation of the completion counter.
        for (int i = 0; i < 260; i++) begin
            do_access(i[0], i[4:0], i[7:0] ^ 8'h5A, 0, 1'b0);
        end
        check("sat_count", access_count, 255);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
